// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Optional feature macro used by the top: FETCH_BOUNDS_CHECK_EN.
package fetch_pkg;

  // Sequencer control states; encoding is visible on the debug state port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Instruction word that stops fetching once it has been handed to decode.
  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_0000;

  // Return buffer depth: one slot per cycle of memory latency plus one for
  // the word decode is currently looking at.
  localparam int BUF_DEPTH = 2;

  // Width of the buffer occupancy counter (0..BUF_DEPTH).
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of {instr, pc} pairs returned from instruction memory.
// Push and pop in the same cycle keep the occupancy unchanged; flush empties
// the buffer and wins over a simultaneous push or pop.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int PC_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [31:0]      push_instr_i,
  input  logic [PC_W-1:0]  push_pc_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic [31:0]      head_instr_o,
  output logic [PC_W-1:0]  head_pc_o
);

  logic [31:0]      instr_q [BUF_DEPTH];
  logic [PC_W-1:0]  pc_q    [BUF_DEPTH];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Storage, pointers and occupancy; flush resets pointers without touching data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        instr_q[wr_ptr_q] <= push_instr_i;
        pc_q[wr_ptr_q]    <= push_pc_i;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o      = count_q;
  assign head_instr_o = instr_q[rd_ptr_q];
  assign head_pc_o    = pc_q[rd_ptr_q];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one read per cycle to a
// synchronous (1-cycle latency) instruction memory when buffer credit allows,
// and hands returned words to decode over valid/ready.
// Optional feature macro: FETCH_BOUNDS_CHECK_EN (redirects beyond SIZE-1
// raise a sticky fetch_fault and halt the sequencer).
//
// Handshake: decode takes a word on any rising edge where out_valid and
// out_ready are both high; while out_valid=1 and out_ready=0 the presented
// out_instr/out_pc stay unchanged, and out_valid never drops without a transfer
// except on redirect, halt or reset.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                  ADDRESS_WIDTH = 6,
  parameter int                  SIZE          = 32,
  parameter logic [ADDRESS_WIDTH:0] RESET_PC   = '0,
  parameter logic [31:0]         HALT_INSTR    = HALT_INSTR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADDRESS_WIDTH:0] imem_pc,
  input  logic [31:0]          imem_instr,
  input  logic                 br_valid,
  input  logic [ADDRESS_WIDTH:0] br_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [ADDRESS_WIDTH:0] out_pc,
  output logic                 halted,
  output logic                 fetch_fault,
  output logic [1:0]           dbg_state
);

  localparam int              PC_W    = ADDRESS_WIDTH + 1;
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(SIZE - 1);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] rd_pc_q, rd_pc_d;
  logic            inflight_q, inflight_d;

  logic             buf_flush;
  logic             buf_push;
  logic             buf_pop;
  logic [CNT_W-1:0] buf_count;
  logic [31:0]      head_instr;
  logic [PC_W-1:0]  head_pc;

  logic             transfer;
  logic             halt_seen;
  logic [CNT_W:0]   occupancy;
  logic             credit_ok;

`ifdef FETCH_BOUNDS_CHECK_EN
  logic fault_q, fault_d;
  logic target_oob;
  assign target_oob = (32'(br_target) >= 32'(SIZE));
`endif

  fetch_skid_buf #(
    .PC_W (PC_W)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (buf_flush),
    .push_i       (buf_push),
    .push_instr_i (imem_instr),
    .push_pc_i    (rd_pc_q),
    .pop_i        (buf_pop),
    .count_o      (buf_count),
    .head_instr_o (head_instr),
    .head_pc_o    (head_pc)
  );

  assign out_valid = (buf_count != '0);
  assign transfer  = out_valid & out_ready;
  assign halt_seen = transfer & (head_instr == HALT_INSTR);

  // Words already owed to the buffer (stored plus in flight), minus the one
  // leaving this cycle; a new read is only safe while this stays below depth.
  assign occupancy = {1'b0, buf_count} + {{CNT_W{1'b0}}, inflight_q}
                     - {{CNT_W{1'b0}}, transfer};
  assign credit_ok = (occupancy < (CNT_W + 1)'(BUF_DEPTH));

  // Next-state, PC, issue and buffer control; redirect takes priority over halt.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rd_pc_d    = rd_pc_q;
    inflight_d = 1'b0;
    buf_flush  = 1'b0;
    buf_push   = 1'b0;
    buf_pop    = transfer;
`ifdef FETCH_BOUNDS_CHECK_EN
    fault_d    = fault_q;
`endif
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d   = RUN;
          pc_d      = RESET_PC;
          buf_flush = 1'b1;
`ifdef FETCH_BOUNDS_CHECK_EN
          fault_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        buf_push = inflight_q;
        if (br_valid) begin
          buf_flush = 1'b1;
          buf_push  = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
          if (target_oob) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else begin
            pc_d = br_target;
          end
`else
          pc_d = br_target;
`endif
        end else if (halt_seen) begin
          state_d   = HALT;
          buf_flush = 1'b1;
          buf_push  = 1'b0;
        end else if (credit_ok) begin
          inflight_d = 1'b1;
          rd_pc_d    = pc_q;
          pc_d       = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        buf_flush = 1'b1;
      end
    endcase
  end

  // Control state, PC and in-flight read tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      rd_pc_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rd_pc_q    <= rd_pc_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef FETCH_BOUNDS_CHECK_EN
  // Sticky fault flag, cleared only by reset or a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  assign imem_pc   = pc_q;
  assign out_instr = out_valid ? head_instr : '0;
  assign out_pc    = out_valid ? head_pc : '0;
  assign halted    = (state_q == HALT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural synchronous memory, directed
// scenarios, an expected-word queue drained by a monitor on the falling edge.
module tb_fetch_sequencer;

  localparam int AW = 6;
  localparam int PW = AW + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW:0]   imem_pc;
  logic [31:0]   imem_instr;
  logic          br_valid;
  logic [AW:0]   br_target;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW:0]   out_pc;
  logic          halted;
  logic          fetch_fault;
  logic [1:0]    dbg_state;

  logic [31:0]   mem [128];
  logic [PW+31:0] exp_q[$];

  int checks;
  int errors;

  fetch_sequencer #(
    .ADDRESS_WIDTH (AW),
    .SIZE          (32),
    .RESET_PC      (7'd0),
    .HALT_INSTR    (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .imem_pc     (imem_pc),
    .imem_instr  (imem_instr),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .halted      (halted),
    .fetch_fault (fetch_fault),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous instruction memory, one cycle of read latency
  always @(posedge clk) imem_instr <= mem[imem_pc];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int pc);
    exp_q.push_back({PW'(pc), mem[pc]});
  endtask

  task automatic wait_halted(input string name, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(halted), 32'd1);
  endtask

  // scoreboard monitor: every accepted word must match the queue head
  task automatic monitor();
    logic [PW+31:0] exp;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got pc %0d instr %h expected none", out_pc, out_instr);
        end else begin
          exp = exp_q.pop_front();
          if ({out_pc, out_instr} !== exp) begin
            errors++;
            $display("FAIL sb_word got pc %0d instr %h expected pc %0d instr %h",
                     out_pc, out_instr, exp[PW+31:32], exp[31:0]);
          end
        end
      end
    end
  endtask

  // start with decode stalled, let two words buffer, then redirect
  task automatic redirect_run(input int target, input string tag);
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check({tag, "_buf_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_buf_pc"}, 32'(out_pc), 32'd0);
    br_valid  = 1'b1;
    br_target = PW'(target);
    tick();
    br_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_r1_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_r1_imem_pc"}, 32'(imem_pc), 32'(target));
    tick();
    check({tag, "_r2_valid"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_r3_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_r3_pc"}, 32'(out_pc), 32'(target));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    start     = 1'b0;
    br_valid  = 1'b0;
    br_target = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[5] = 32'h0000_0000;
    fork
      monitor();
    join_none

    // reset state
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_imem_pc", 32'(imem_pc), 32'd0);
    check("rst_out_pc", 32'(out_pc), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    tick();

    // stream 0..5, halting on the HALT word at 5
    for (int p = 0; p <= 5; p++) push_exp(p);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lat_c1_valid", 32'(out_valid), 32'd0);
    check("run_state", 32'(dbg_state), 32'd1);
    tick();
    check("lat_c2_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_c3_valid", 32'(out_valid), 32'd1);
    check("lat_c3_pc", 32'(out_pc), 32'd0);
    tick(); tick(); tick(); tick(); tick();
    check("halt_word_pc", 32'(out_pc), 32'd5);
    check("halt_word_pre", 32'(halted), 32'd0);
    tick();
    check("halt_next", 32'(halted), 32'd1);
    check("halt_valid", 32'(out_valid), 32'd0);
    tick(); tick(); tick();
    check("halt_quiet", 32'(out_valid), 32'd0);

    // restart from RESET_PC, stall decode for five cycles mid-stream
    mem[5]  = 32'h1000_0005;
    mem[12] = 32'h0000_0000;
    for (int p = 0; p <= 12; p++) push_exp(p);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_pc", 32'(out_pc), 32'd3);
      check("stall_instr", out_instr, 32'h1000_0003);
      check("stall_imem_pc", 32'(imem_pc), 32'd5);
      tick();
    end
    out_ready = 1'b1;
    wait_halted("stall_halt", 60);

    // redirect to 20 while two words are buffered; halt word at 24
    mem[24] = 32'h0000_0000;
    for (int p = 20; p <= 24; p++) push_exp(p);
    redirect_run(20, "br20");
    wait_halted("br20_halt", 40);

    // redirect to 30 and wrap past SIZE-1; halt word at 1
    mem[1] = 32'h0000_0000;
    push_exp(30); push_exp(31); push_exp(0); push_exp(1);
    redirect_run(30, "wrap");
    wait_halted("wrap_halt", 40);

    // reset in the middle of a stream
    mem[1] = 32'h1000_0001;
    push_exp(0); push_exp(1); push_exp(2);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_out_pc", 32'(out_pc), 32'd0);
    check("arst_instr", out_instr, 32'd0);
    check("arst_imem_pc", 32'(imem_pc), 32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(); tick();
    check("post_rst_state", 32'(dbg_state), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // out-of-range redirect target
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    br_valid  = 1'b1;
    br_target = 7'd40;
    tick();
    br_valid  = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
    check("oob_fault", 32'(fetch_fault), 32'd1);
    check("oob_halted", 32'(halted), 32'd1);
    check("oob_valid", 32'(out_valid), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("oob_fault_clr", 32'(fetch_fault), 32'd0);
`else
    check("oob_imem_pc", 32'(imem_pc), 32'd40);
    check("oob_fault", 32'(fetch_fault), 32'd0);
    check("oob_halted", 32'(halted), 32'd0);
`endif

    // drain: every expected word must have been seen
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
